// File: rtl/pixel_frame_packer_if.sv
// Stream/frame bundle for pixel_frame_packer.
//   slave  modport (packer side): takes the pixel stream (s_valid/s_data/s_sof) and frame_ack,
//                                 drives s_ready, frame_out, frame_valid, sof_err.
//   master modport (source/consumer side): the mirror image.
interface pixel_frame_packer_if #(
  parameter int unsigned PIX_BITS = 8,
  parameter int unsigned NPIX     = 1024
);
  logic                s_valid;
  logic                s_ready;
  logic [PIX_BITS-1:0] s_data;
  logic                s_sof;
  logic [NPIX-1:0]     frame_out;
  logic                frame_valid;
  logic                frame_ack;
  logic                sof_err;

  modport slave (
    input  s_valid, s_data, s_sof, frame_ack,
    output s_ready, frame_out, frame_valid, sof_err
  );

  modport master (
    output s_valid, s_data, s_sof, frame_ack,
    input  s_ready, frame_out, frame_valid, sof_err
  );
endinterface

// File: rtl/pixel_frame_packer.sv
// pixel_frame_packer: thresholds a raster stream of grayscale pixels to 1 bit each and packs
// a WIDTH x HEIGHT frame into a flat vector (raster index k -> bit k). A finished frame is
// held stable on frame_out/frame_valid until frame_ack; the next frame fills a second buffer.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - pixel_frame_packer_if.slave: s_valid/s_ready/s_data/s_sof pixel stream,
//          frame_out/frame_valid/frame_ack frame hand-off, sof_err resync pulse
//
// Optional feature: define PACKER_SOF_RESYNC_EN to let an accepted s_sof force that pixel to
// index 0 (sof_err pulses if a partial frame is dropped). Without it s_sof is ignored and
// sof_err is always 0.
module pixel_frame_packer #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned HEIGHT    = 32,
  parameter int unsigned PIX_BITS  = 8,
  parameter int unsigned THRESHOLD = 128,
  parameter int unsigned CNT_WIDTH = 10
) (
  input logic                  clk,
  input logic                  rst,
  pixel_frame_packer_if.slave  bus
);
  localparam int unsigned NPIX = WIDTH * HEIGHT;

  typedef enum logic [0:0] {StFill, StPend} state_e;

  state_e               state_q, state_d;
  logic [NPIX-1:0]      fill_q, fill_d;
  logic [NPIX-1:0]      frame_q, frame_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, idx;
  logic                 valid_q, valid_d;
  logic                 ready_q, ready_d;
  logic                 sof_err_q, sof_err_d;
  logic                 accept, pix_bit, complete, out_free, transfer;

  assign accept   = bus.s_valid & ready_q;
  assign pix_bit  = (32'(bus.s_data) >= THRESHOLD);
  // Output slot is usable if empty, or if the consumer releases it this very cycle.
  assign out_free = ~valid_q | bus.frame_ack;

`ifndef PACKER_SOF_RESYNC_EN
  logic unused_sof;
  assign unused_sof = bus.s_sof;
`endif

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    frame_d   = frame_q;
    valid_d   = valid_q;
    sof_err_d = 1'b0;
    idx       = cnt_q;
    complete  = 1'b0;
    transfer  = 1'b0;

`ifdef PACKER_SOF_RESYNC_EN
    if (accept && bus.s_sof) begin
      idx       = '0;
      sof_err_d = (cnt_q != '0);
    end
`endif

    if (accept) begin
      fill_d[idx] = pix_bit;
      complete    = (idx == CNT_WIDTH'(NPIX - 1));
      cnt_d       = complete ? '0 : idx + 1'b1;
    end

    case (state_q)
      StFill: begin
        if (complete) begin
          if (out_free) transfer = 1'b1;
          else          state_d  = StPend;
        end
      end
      StPend: begin
        if (out_free) begin
          transfer = 1'b1;
          state_d  = StFill;
        end
      end
      default: state_d = StFill;
    endcase

    // fill_d already holds the final pixel when the frame completes on this edge.
    if (transfer) begin
      frame_d = fill_d;
      valid_d = 1'b1;
    end else if (bus.frame_ack) begin
      valid_d = 1'b0;
    end

    ready_d = (state_d == StFill);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFill;
      fill_q    <= '0;
      cnt_q     <= '0;
      frame_q   <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
      sof_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      frame_q   <= frame_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      sof_err_q <= sof_err_d;
    end
  end

  assign bus.s_ready     = ready_q;
  assign bus.frame_out   = frame_q;
  assign bus.frame_valid = valid_q;
  assign bus.sof_err     = sof_err_q;
endmodule

// File: tb/tb_pixel_frame_packer.sv
module tb_pixel_frame_packer;
  localparam int unsigned NPIX = 1024;

`ifdef PACKER_SOF_RESYNC_EN
  localparam bit SofOn = 1'b1;
`else
  localparam bit SofOn = 1'b0;
`endif

  typedef struct {
    string          name;
    logic [3:0][7:0] v;    // pixel value for k%4 == 0..3
    logic [3:0]      nib;  // expected bit for k%4 == 0..3
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  pixel_frame_packer_if #(.PIX_BITS(8), .NPIX(NPIX)) bus ();

  pixel_frame_packer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_frame(input string name, input logic [NPIX-1:0] got,
                             input logic [NPIX-1:0] exp);
    int first;
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      first = -1;
      for (int k = NPIX - 1; k >= 0; k--) if (got[k] !== exp[k]) first = k;
      $display("FAIL %s: frame_out low128 got %h, expected %h, first bad bit %0d",
               name, got[127:0], exp[127:0], first);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [7:0] a0, input logic [7:0] a1,
                              input logic [7:0] a2, input logic [7:0] a3, input logic [3:0] nib);
    vec_t r;
    r.name = name;
    r.v[0] = a0; r.v[1] = a1; r.v[2] = a2; r.v[3] = a3;
    r.nib  = nib;
    return r;
  endfunction

  function automatic logic [NPIX-1:0] rep_nib(input logic [3:0] nib);
    logic [NPIX-1:0] r;
    for (int k = 0; k < NPIX; k++) r[k] = nib[k % 4];
    return r;
  endfunction

  // One cycle of offered data; acc reports whether the pixel was taken at this edge.
  task automatic push(input logic [7:0] val, input logic sof, output bit acc);
    bus.s_valid = 1'b1;
    bus.s_data  = val;
    bus.s_sof   = sof;
    acc = bus.s_ready;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_sof   = 1'b0;
  endtask

  task automatic ack_pulse();
    bus.frame_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.frame_ack = 1'b0;
  endtask

  // Streams a full frame with no gaps; returns stall count and frame_valid just before the
  // final pixel's edge.
  task automatic stream(input vec_t t, output int stalls, output bit valid_before_last);
    bit acc;
    stalls = 0;
    valid_before_last = 1'b0;
    for (int k = 0; k < NPIX; k++) begin
      if (k == NPIX - 1) valid_before_last = bus.frame_valid;
      push(t.v[k % 4], 1'b0, acc);
      if (!acc) stalls++;
    end
  endtask

  initial begin
    vec_t            tbl [5];
    vec_t            f1, f2, f3;
    int              stalls, n;
    bit              vb, acc, done;
    logic [NPIX-1:0] exp;

    tbl[0] = mk("alt200_10",   200, 10,  200, 10,  4'b0101);
    tbl[1] = mk("thresh_edge", 127, 128, 255, 0,   4'b0110);
    tbl[2] = mk("all128",      128, 128, 128, 128, 4'b1111);
    tbl[3] = mk("all_below",   127, 0,   1,   127, 4'b0000);
    tbl[4] = mk("mixed",       255, 127, 0,   129, 4'b1001);
    f1 = mk("bp_f1", 200, 10,  200, 10,  4'b0101);
    f2 = mk("bp_f2", 200, 200, 0,   0,   4'b0011);
    f3 = mk("post_rst", 255, 0, 0,  128, 4'b1001);

    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_sof = 1'b0; bus.frame_ack = 1'b0;

    // Reset
    @(posedge clk); #1;
    check_val("rst_ready",       int'(bus.s_ready), 0);
    check_val("rst_frame_valid", int'(bus.frame_valid), 0);
    check_frame("rst_frame_out", bus.frame_out, '0);
    check_val("rst_sof_err",     int'(bus.sof_err), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_val("ready_after_rst", int'(bus.s_ready), 1);

    // Table-driven frames, output slot freed before each one
    foreach (tbl[i]) begin
      if (bus.frame_valid) ack_pulse();
      stream(tbl[i], stalls, vb);
      check_val({tbl[i].name, "_stalls"},      stalls, 0);
      check_val({tbl[i].name, "_valid_early"}, int'(vb), 0);
      check_val({tbl[i].name, "_valid"},       int'(bus.frame_valid), 1);
      check_frame({tbl[i].name, "_frame"},     bus.frame_out, rep_nib(tbl[i].nib));
    end

    // Backpressure: second frame completes with no ack -> PEND
    ack_pulse();
    stream(f1, stalls, vb);
    stream(f2, stalls, vb);
    check_val("bp_f2_stalls", stalls, 0);
    check_val("bp_ready_low", int'(bus.s_ready), 0);
    check_frame("bp_hold_f1", bus.frame_out, rep_nib(f1.nib));
    bus.s_valid = 1'b1; bus.s_data = 8'd255;
    repeat (3) @(posedge clk);
    #1;
    check_val("bp_ready_still_low", int'(bus.s_ready), 0);
    check_val("bp_valid_held",      int'(bus.frame_valid), 1);
    check_frame("bp_still_f1", bus.frame_out, rep_nib(f1.nib));
    ack_pulse();
    bus.s_valid = 1'b0;
    check_frame("bp_f2_loaded",   bus.frame_out, rep_nib(f2.nib));
    check_val("bp_valid_no_gap",  int'(bus.frame_valid), 1);
    check_val("bp_ready_back",    int'(bus.s_ready), 1);

    // Ack with nothing pending, then ack while invalid
    ack_pulse();
    check_val("ack_drops_valid", int'(bus.frame_valid), 0);
    ack_pulse();
    check_val("ack_idle_ignored", int'(bus.frame_valid), 0);
    check_frame("ack_out_kept", bus.frame_out, rep_nib(f2.nib));

    // SOF mid-frame at pixel 500
    for (int k = 0; k < 500; k++) push(8'd0, 1'b0, acc);
    push(8'd255, 1'b1, acc);
    check_val("sof_err_pulse", int'(bus.sof_err), SofOn ? 1 : 0);
    n = 0;
    done = 1'b0;
    while (!done && n < 1100) begin
      push(8'd0, 1'b0, acc);
      n++;
      if (n == 1) check_val("sof_err_one_cycle", int'(bus.sof_err), 0);
      if (bus.frame_valid) done = 1'b1;
    end
    check_val("sof_complete_count", n, SofOn ? 1023 : 523);
    exp = '0;
    if (SofOn) exp[0] = 1'b1;
    else       exp[500] = 1'b1;
    check_frame("sof_frame", bus.frame_out, exp);

    // Reset mid-frame with a frame held
    for (int k = 0; k < 300; k++) push(8'd255, 1'b0, acc);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("mrst_valid", int'(bus.frame_valid), 0);
    check_frame("mrst_frame_out", bus.frame_out, '0);
    check_val("mrst_ready", int'(bus.s_ready), 0);
    @(posedge clk); #1;
    check_val("mrst_ready_back", int'(bus.s_ready), 1);
    stream(f3, stalls, vb);
    check_val("mrst_new_valid", int'(bus.frame_valid), 1);
    check_frame("mrst_new_frame", bus.frame_out, rep_nib(f3.nib));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
